// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between a byte producer and the UART transmitter FIFO.
// The producer (master) drives din/din_vld; the transmitter (slave)
// answers with din_rdy. A byte moves on any edge where din_vld && din_rdy.
interface uart_tx_fifo_if;
  logic [7:0] din;
  logic       din_vld;
  logic       din_rdy;

  modport master (
    output din,
    output din_vld,
    input  din_rdy
  );

  modport slave (
    input  din,
    input  din_vld,
    output din_rdy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a 4-entry byte FIFO.
// Bytes arrive over a valid/ready handshake and leave as 8N1 frames
// (start 0, 8 data bits LSB first, stop 1) on tx_uart, each bit held for
// T clock cycles. Queued bytes are sent back-to-back with no idle gap.
// Reset is asynchronous and active-high on the port named rst_n.
module uart_tx_fifo #(
  parameter int unsigned T = 5208
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_fifo_if.slave   host,
  output logic            tx_uart,
  output logic            busy
);

  localparam logic [15:0] T_LAST = 16'(T - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_c;
  state_t      state_n;

  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        din_rdy;
  logic        push;
  logic        pop;

  logic [15:0] cnt0;
  logic        end_cnt0;
  logic [2:0]  cnt1;
  logic [7:0]  shreg;

  // A full FIFO refuses input even when a pop happens on the same edge,
  // so there is never a write-through path from din to the head slot.
  assign din_rdy      = (count != 3'd4);
  assign host.din_rdy = din_rdy;
  assign push         = host.din_vld && din_rdy;
  assign end_cnt0     = (state_c != IDLE) && (cnt0 == T_LAST);
  assign busy         = (state_c != IDLE) || (count != 3'd0);

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_c <= IDLE;
    else       state_c <= state_n;
  end

  // Next-state logic; pop is raised whenever a new frame is started, either
  // from idle or straight out of a stop bit so that queued frames abut.
  always_comb begin
    state_n = state_c;
    pop     = 1'b0;
    case (state_c)
      IDLE: begin
        if (count != 3'd0) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (end_cnt0) state_n = DATA;
      end
      DATA: begin
        if (end_cnt0 && (cnt1 == 3'd7)) state_n = STOP;
      end
      STOP: begin
        if (end_cnt0) begin
          if (count != 3'd0) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO storage holds only data, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host.din;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Bit timer: idles at zero and restarts at every bit boundary, which is
  // also every state entry since all transitions out of a bit happen there.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                           cnt0 <= 16'd0;
    else if (state_c == IDLE || end_cnt0) cnt0 <= 16'd0;
    else                                 cnt0 <= cnt0 + 16'd1;
  end

  // Data bit index; wraps 7->0 naturally as the frame enters STOP.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                            cnt1 <= 3'd0;
    else if (state_c == DATA && end_cnt0) cnt1 <= cnt1 + 3'd1;
  end

  // Shift register: loaded with the head byte on pop, shifted right after
  // each data bit so the next bit to send is always at bit 1 / bit 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)                            shreg <= 8'd0;
    else if (pop)                         shreg <= mem[rd_ptr];
    else if (state_c == DATA && end_cnt0) shreg <= {1'b0, shreg[7:1]};
  end

  // Registered line driver: each bit level is set on the edge that starts it.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tx_uart <= 1'b1;
    end else if (pop) begin
      tx_uart <= 1'b0;
    end else if (state_c == IDLE) begin
      tx_uart <= 1'b1;
    end else if (end_cnt0) begin
      case (state_c)
        START:   tx_uart <= shreg[0];
        DATA:    tx_uart <= (cnt1 == 3'd7) ? 1'b1 : shreg[1];
        default: tx_uart <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance at T=16 for frame shape,
// back-to-back, FIFO-full and mid-frame reset cases, and one at T=5208 for
// the real baud timing.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_a, busy_a;
  logic tx_b, busy_b;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_fifo_if bus_a ();
  uart_tx_fifo_if bus_b ();

  uart_tx_fifo #(.T(16)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (bus_a),
    .tx_uart (tx_a),
    .busy    (busy_a)
  );

  uart_tx_fifo #(.T(5208)) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .host    (bus_b),
    .tx_uart (tx_b),
    .busy    (busy_b)
  );

  // 100 MHz-style bench clock; absolute period is irrelevant, only cycles count.
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk one 10-bit frame cycle by cycle from frame cycle start_idx, which
  // must be the current cycle. Line level, busy and din_rdy are compared
  // every cycle; the byte is also recovered by sampling at bit centres.
  // Returns at the cycle just after the frame's last stop cycle.
  task automatic check_frame(input bit sel, input logic [7:0] data, input int start_idx,
                             input logic exp_rdy, input string tag);
    int         per;
    int         bit_bad [10];
    int         busy_bad;
    int         rdy_bad;
    int         idx;
    logic [7:0] recovered;
    logic       exp_bit;
    logic       obs_tx, obs_busy, obs_rdy;
    per       = sel ? 5208 : 16;
    busy_bad  = 0;
    rdy_bad   = 0;
    recovered = 8'h00;
    for (int b = 0; b < 10; b++) bit_bad[b] = 0;
    for (int i = start_idx; i < 10 * per; i++) begin
      idx      = i / per;
      exp_bit  = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : data[idx-1];
      obs_tx   = sel ? tx_b : tx_a;
      obs_busy = sel ? busy_b : busy_a;
      obs_rdy  = sel ? bus_b.din_rdy : bus_a.din_rdy;
      if (obs_tx !== exp_bit)  bit_bad[idx]++;
      if (obs_busy !== 1'b1)   busy_bad++;
      if (obs_rdy !== exp_rdy) rdy_bad++;
      if (idx >= 1 && idx <= 8 && (i % per) == per / 2) recovered[idx-1] = obs_tx;
      tick();
    end
    for (int b = 0; b < 10; b++)
      check_output($sformatf("%s bit%0d bad cycles", tag, b), bit_bad[b], 0);
    check_output({tag, " busy bad cycles"}, busy_bad, 0);
    check_output({tag, " din_rdy bad cycles"}, rdy_bad, 0);
    check_output({tag, " recovered byte"}, {24'd0, recovered}, {24'd0, data});
  endtask

  // Line must be idle and nothing pending.
  task automatic check_idle(input string tag);
    check_output({tag, " tx idle"}, {31'd0, tx_a}, 32'd1);
    check_output({tag, " busy low"}, {31'd0, busy_a}, 32'd0);
    check_output({tag, " din_rdy"}, {31'd0, bus_a.din_rdy}, 32'd1);
  endtask

  initial begin
    int tx_bad;
    int busy_bad;
    int rdy_bad;

    bus_a.din     = 8'h00;
    bus_a.din_vld = 1'b0;
    bus_b.din     = 8'h00;
    bus_b.din_vld = 1'b0;
    rst_n         = 1'b1;

    // Reset values, both while held and after release.
    repeat (3) tick();
    check_idle("reset held");
    check_output("reset held tx_b", {31'd0, tx_b}, 32'd1);
    check_output("reset held busy_b", {31'd0, busy_b}, 32'd0);
    rst_n = 1'b0;
    repeat (2) tick();
    check_idle("after release");

    // Single 0x55: start bit one cycle after the accept edge.
    $display("[TB] single byte 0x55");
    bus_a.din     = 8'h55;
    bus_a.din_vld = 1'b1;
    tick();
    bus_a.din_vld = 1'b0;
    check_output("55 tx before start", {31'd0, tx_a}, 32'd1);
    check_output("55 busy on accept", {31'd0, busy_a}, 32'd1);
    tick();
    check_frame(1'b0, 8'h55, 0, 1'b1, "f55");
    check_idle("after 55");

    // 0x00 then 0xFF back-to-back with no idle cycle between frames.
    $display("[TB] back-to-back 0x00 0xFF");
    bus_a.din     = 8'h00;
    bus_a.din_vld = 1'b1;
    tick();
    bus_a.din     = 8'hFF;
    tick();
    bus_a.din_vld = 1'b0;
    check_frame(1'b0, 8'h00, 0, 1'b1, "f00");
    check_frame(1'b0, 8'hFF, 0, 1'b1, "fFF");
    check_idle("after FF");

    // Hold din_vld with 0x01..0x06: fill the FIFO, wait for the pop.
    $display("[TB] fifo full 0x01..0x06");
    bus_a.din     = 8'h01;
    bus_a.din_vld = 1'b1;
    tick();
    check_output("fill rdy after 01", {31'd0, bus_a.din_rdy}, 32'd1);
    bus_a.din = 8'h02;
    tick();
    check_output("fill start bit 01", {31'd0, tx_a}, 32'd0);
    check_output("fill rdy after 02", {31'd0, bus_a.din_rdy}, 32'd1);
    bus_a.din = 8'h03;
    tick();
    bus_a.din = 8'h04;
    tick();
    check_output("fill rdy after 04", {31'd0, bus_a.din_rdy}, 32'd1);
    bus_a.din = 8'h05;
    tick();
    check_output("fill rdy full", {31'd0, bus_a.din_rdy}, 32'd0);
    bus_a.din = 8'h06;
    check_frame(1'b0, 8'h01, 3, 1'b0, "f01");
    check_output("fill rdy after pop", {31'd0, bus_a.din_rdy}, 32'd1);
    tick();
    // 0x06 is taken; keep offering 0xEE while full, it must be ignored.
    bus_a.din = 8'hEE;
    check_frame(1'b0, 8'h02, 1, 1'b0, "f02");
    bus_a.din_vld = 1'b0;
    check_frame(1'b0, 8'h03, 0, 1'b1, "f03");
    check_frame(1'b0, 8'h04, 0, 1'b1, "f04");
    check_frame(1'b0, 8'h05, 0, 1'b1, "f05");
    check_frame(1'b0, 8'h06, 0, 1'b1, "f06");
    check_idle("after fill");

    // Asynchronous reset during data bit 3 of 0xA5 with two bytes queued.
    $display("[TB] reset mid-frame");
    bus_a.din     = 8'hA5;
    bus_a.din_vld = 1'b1;
    tick();
    bus_a.din = 8'h11;
    tick();
    bus_a.din = 8'h22;
    tick();
    bus_a.din_vld = 1'b0;
    repeat (69) tick();
    check_output("A5 bit3 before reset", {31'd0, tx_a}, 32'd0);
    check_output("A5 busy before reset", {31'd0, busy_a}, 32'd1);
    #2 rst_n = 1'b1;
    #1;
    check_idle("async reset");
    tick();
    tick();
    rst_n    = 1'b0;
    tx_bad   = 0;
    busy_bad = 0;
    rdy_bad  = 0;
    for (int i = 0; i < 500; i++) begin
      if (tx_a !== 1'b1)          tx_bad++;
      if (busy_a !== 1'b0)        busy_bad++;
      if (bus_a.din_rdy !== 1'b1) rdy_bad++;
      tick();
    end
    check_output("post reset tx bad cycles", tx_bad, 0);
    check_output("post reset busy bad cycles", busy_bad, 0);
    check_output("post reset rdy bad cycles", rdy_bad, 0);

    // Real baud divisor: 0x3C at T=5208.
    $display("[TB] T=5208 byte 0x3C");
    bus_b.din     = 8'h3C;
    bus_b.din_vld = 1'b1;
    tick();
    bus_b.din_vld = 1'b0;
    check_output("3C tx before start", {31'd0, tx_b}, 32'd1);
    tick();
    check_frame(1'b1, 8'h3C, 0, 1'b1, "f3C");
    check_output("3C tx idle after", {31'd0, tx_b}, 32'd1);
    check_output("3C busy low after", {31'd0, busy_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

UART transmitter for the course-experiment serial link: accepts bytes over a valid/ready handshake into a 4-entry FIFO and serialises each as an 8N1 frame (start bit 0, 8 data bits LSB first, stop bit 1) on `tx_uart`. It pairs with the team's UART receiver at the same baud divisor: 9600 baud from a 50 MHz clock, T = 5208. It sits between byte-producing logic (key scanner, test pattern source) and the board's UART TX pin.

## Interface
- `T`, default 5208: clock cycles per bit; legal range 2..65535.
- `DEPTH`, fixed at 4: FIFO entries. This is not a parameter; it is listed for reference.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  one clock; reset is asynchronous and active-high. The port keeps the codebase's reset name; asserted = 1.
- `din`  in  8  byte to transmit.
- `din_vld`  in  1  `din` valid.
- `din_rdy`  out  1  FIFO can accept a byte this cycle.
- `tx_uart`  out  1  serial line, idle high, registered.
- `busy`  out  1  frame in progress or FIFO non-empty.

## Operation
- **Accept:** a byte is accepted on any rising edge where `din_vld && din_rdy`. It is written at the FIFO write pointer.
- **FIFO:**
  - 4 entries, 2-bit pointers that wrap 3→0.
  - 3-bit count, range 0..4.
  - `din_rdy = (count != 4)`.
  - A push and a pop on the same edge leave the count unchanged.
  - When full, `din_rdy` is 0 even if a pop occurs on that edge. There is no write-through.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx_uart = 1`. If count != 0, pop the head byte into an 8-bit shift register, go to START, and set `tx_uart <= 0`.
  - START: hold 0 for T cycles, then go to DATA and set `tx_uart <= shreg[0]`.
  - DATA: each bit is held T cycles. On the bit end, shift right and advance the bit counter (0..7). After bit 7, go to STOP and set `tx_uart <= 1`.
  - STOP: hold 1 for T cycles. At the end, if count != 0, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- **Bit timer:**
  - 16-bit counter `cnt0`, active outside IDLE.
  - Counts 0..T-1; `end_cnt0` fires at T-1.
  - Clears to 0 on state entry.
- **Bit counter:** `cnt1` is 3 bits, counts only in DATA, and wraps 7→0 on entry to STOP.
- **busy:** `(state != IDLE) || (count != 0)`, combinational.
- **Reset (asynchronous, any time, including mid-frame):**
  - `tx_uart` = 1 and state = IDLE.
  - FIFO emptied (pointers and count 0); `cnt0` and `cnt1` = 0.
  - `busy` = 0 and `din_rdy` = 1.
  - A partially sent frame is abandoned. Bytes are only accepted on clock edges after reset deasserts.

## Timing
- **Reset values:** `tx_uart` = 1, `busy` = 0, `din_rdy` = 1.
- **Latency:** byte accepted on edge E0 with the FIFO empty and FSM in IDLE → `tx_uart` falls after edge E1. The start bit begins one cycle after acceptance.
- **Frame length:** exactly 10·T cycles (start + 8 data + stop), with each bit exactly T cycles.
- **Back-to-back:** the next start bit follows the stop bit's last cycle with zero gap while the FIFO is non-empty.
- **busy:** goes high on the edge that accepts the first byte. It falls on the edge that leaves STOP for IDLE.
- **Pop vs. din_rdy:** a pop raises `din_rdy` from 0 to 1 on the following cycle.

## Test plan
- T = 16, send 0x55 after reset → `tx_uart` falls 1 cycle after accept. The line reads 0,1,0,1,0,1,0,1,0,1, each level 16 cycles; frame is 160 cycles; `busy` falls on the last stop cycle's edge.
- T = 16, send 0x00 then 0xFF back-to-back → two contiguous 160-cycle frames with no idle cycle. Data is all-0 then all-1, stop bits = 1.
- T = 16, hold `din_vld` = 1 with bytes 0x01..0x06 from idle:
  - Accepts 0x01 at E0; 0x01 is popped at E1.
  - Then accepts 0x02..0x05 (FIFO full, `din_rdy` = 0).
  - Next accept (0x06) occurs the cycle after 0x02 is popped.
  - Line carries 0x01..0x06 in order.
- T = 16, assert `rst_n` = 1 in the middle of data bit 3 of 0xA5 with 2 bytes queued → `tx_uart` = 1 immediately (asynchronously); `busy` = 0, `din_rdy` = 1. After release with no input, the line stays high for 500 cycles.
- T = 5208, send 0x3C → each bit measures 5208 cycles (104.16 µs at 50 MHz). Sampling the line at bit centres recovers 0x3C.
- `din_vld` pulses while `din_rdy` = 0 → byte ignored; FIFO count and line output are unchanged.
